// File: rtl/uart_wb_arbiter_pkg.sv
// Shared types and widths for the two-master UART wishbone arbiter.
package uart_wb_arbiter_pkg;

  localparam int unsigned UART_AW = 2;
  localparam int unsigned UART_DW = 8;
  localparam int unsigned BURST_W = 4;
  localparam int unsigned LAT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STROBE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  // One latched slave access request.
  typedef struct packed {
    logic               we;
    logic [UART_AW-1:0] addr;
    logic [UART_DW-1:0] datw;
  } wb_req_t;

endpackage

// File: rtl/uart_wb_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the master not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/uart_wb_arbiter.sv
// Shares the UART wishbone slave port between two masters: one strobe per access,
// fixed read latency, bounded round-robin bursts and a registered interrupt fan-out.
module uart_wb_arbiter
  import uart_wb_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               wb_clk_i,
  input  logic               rst_n_i,
  input  logic               m0_cyc_i,
  input  logic               m0_we_i,
  input  logic [UART_AW-1:0] m0_addr_i,
  input  logic [UART_DW-1:0] m0_datw_i,
  output logic [UART_DW-1:0] m0_datr_o,
  output logic               m0_ack_o,
  output logic               m0_int_o,
  input  logic               m1_cyc_i,
  input  logic               m1_we_i,
  input  logic [UART_AW-1:0] m1_addr_i,
  input  logic [UART_DW-1:0] m1_datw_i,
  output logic [UART_DW-1:0] m1_datr_o,
  output logic               m1_ack_o,
  output logic               m1_int_o,
  output logic               s_cyc_o,
  output logic               s_we_o,
  output logic [UART_AW-1:0] s_addr_o,
  output logic [UART_DW-1:0] s_datw_o,
  input  logic [UART_DW-1:0] s_datr_i,
  input  logic               s_int_i,
  output logic [1:0]         grant_o
);

  localparam logic [LAT_W-1:0]   LAT_LAST  = LAT_W'((RD_LAT == 0) ? 0 : RD_LAT - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  state_t               state_q, state_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 last_q, last_d;
  logic                 owner_q, owner_d;
  logic [1:0]           grant_q, grant_d;
  logic                 s_cyc_q, s_cyc_d;
  logic                 s_we_q, s_we_d;
  wb_req_t              req_q, req_d;
  logic [UART_DW-1:0]   m0_datr_q, m0_datr_d;
  logic [UART_DW-1:0]   m1_datr_q, m1_datr_d;
  logic                 m0_ack_q, m0_ack_d;
  logic                 m1_ack_q, m1_ack_d;
  logic                 int_q;

  wb_req_t              m0_req, m1_req;
  logic [1:0]           cyc_req, gnt;
  logic                 own_cyc;
  logic                 to_ack, arb, cont;

  assign m0_req  = {m0_we_i, m0_addr_i, m0_datw_i};
  assign m1_req  = {m1_we_i, m1_addr_i, m1_datw_i};
  assign cyc_req = {m1_cyc_i, m0_cyc_i};
  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;

  rr_arb2 u_rr_arb2 (
    .req  (cyc_req),
    .last (last_q),
    .gnt  (gnt)
  );

  // Next-state and next-output logic; last_q already names the current owner in GAP.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    burst_d   = burst_q;
    last_d    = last_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    req_d     = req_q;
    s_cyc_d   = 1'b0;
    s_we_d    = 1'b0;
    m0_datr_d = m0_datr_q;
    m1_datr_d = m1_datr_q;
    m0_ack_d  = 1'b0;
    m1_ack_d  = 1'b0;
    to_ack    = 1'b0;
    arb       = 1'b0;
    cont      = 1'b0;

    case (state_q)
      ST_IDLE: arb = 1'b1;
      ST_STROBE: begin
        if (RD_LAT == 0) begin
          to_ack = 1'b1;
        end else begin
          state_d = ST_WAIT;
          lat_d   = '0;
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_LAST) begin
          to_ack = 1'b1;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_ACK: state_d = ST_GAP;
      ST_GAP: begin
        if (own_cyc && (burst_q < BURST_MAX)) begin
          cont = 1'b1;
        end else begin
          arb = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ack and read data are only delivered if the owner still holds cyc.
    if (to_ack) begin
      state_d = ST_ACK;
      if (own_cyc) begin
        if (owner_q) begin
          m1_ack_d = 1'b1;
          if (!req_q.we) m1_datr_d = s_datr_i;
        end else begin
          m0_ack_d = 1'b1;
          if (!req_q.we) m0_datr_d = s_datr_i;
        end
      end
    end

    if (cont) begin
      state_d = ST_STROBE;
      burst_d = burst_q + BURST_W'(1);
      req_d   = owner_q ? m1_req : m0_req;
      s_cyc_d = 1'b1;
      s_we_d  = req_d.we;
    end

    if (arb) begin
      if (gnt != 2'b00) begin
        state_d = ST_STROBE;
        owner_d = gnt[1];
        last_d  = gnt[1];
        grant_d = gnt;
        burst_d = BURST_W'(1);
        req_d   = gnt[1] ? m1_req : m0_req;
        s_cyc_d = 1'b1;
        s_we_d  = req_d.we;
      end else begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      burst_q   <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      grant_q   <= 2'b00;
      s_cyc_q   <= 1'b0;
      s_we_q    <= 1'b0;
      req_q     <= '0;
      m0_datr_q <= '0;
      m1_datr_q <= '0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      s_cyc_q   <= s_cyc_d;
      s_we_q    <= s_we_d;
      req_q     <= req_d;
      m0_datr_q <= m0_datr_d;
      m1_datr_q <= m1_datr_d;
      m0_ack_q  <= m0_ack_d;
      m1_ack_q  <= m1_ack_d;
      int_q     <= s_int_i;
    end
  end

  assign s_cyc_o   = s_cyc_q;
  assign s_we_o    = s_we_q;
  assign s_addr_o  = req_q.addr;
  assign s_datw_o  = req_q.datw;
  assign grant_o   = grant_q;
  assign m0_datr_o = m0_datr_q;
  assign m1_datr_o = m1_datr_q;
  assign m0_ack_o  = m0_ack_q;
  assign m1_ack_o  = m1_ack_q;
  assign m0_int_o  = int_q;
  assign m1_int_o  = int_q;

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Directed bench for uart_wb_arbiter; a second instance with MAX_BURST=1 checks alternation.
module tb_uart_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m0_cyc = 1'b0, m0_we = 1'b0;
  logic [1:0] m0_addr = 2'd0;
  logic [7:0] m0_datw = 8'd0;
  logic       m1_cyc = 1'b0, m1_we = 1'b0;
  logic [1:0] m1_addr = 2'd0;
  logic [7:0] m1_datw = 8'd0;
  logic [7:0] s_datr = 8'd0;
  logic       s_int = 1'b0;

  logic [7:0] m0_datr, m1_datr, s_datw;
  logic       m0_ack, m1_ack, m0_int, m1_int, s_cyc, s_we;
  logic [1:0] s_addr, grant;

  logic [7:0] m0_datr_b, m1_datr_b, s_datw_b;
  logic       m0_ack_b, m1_ack_b, m0_int_b, m1_int_b, s_cyc_b, s_we_b;
  logic [1:0] s_addr_b, grant_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_wb_arbiter #(.RD_LAT(1), .MAX_BURST(4)) u_dut (
    .wb_clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_datw_i(m0_datw),
    .m0_datr_o(m0_datr), .m0_ack_o(m0_ack), .m0_int_o(m0_int),
    .m1_cyc_i(m1_cyc), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_datw_i(m1_datw),
    .m1_datr_o(m1_datr), .m1_ack_o(m1_ack), .m1_int_o(m1_int),
    .s_cyc_o(s_cyc), .s_we_o(s_we), .s_addr_o(s_addr), .s_datw_o(s_datw),
    .s_datr_i(s_datr), .s_int_i(s_int), .grant_o(grant)
  );

  uart_wb_arbiter #(.RD_LAT(1), .MAX_BURST(1)) u_dut_b1 (
    .wb_clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_datw_i(m0_datw),
    .m0_datr_o(m0_datr_b), .m0_ack_o(m0_ack_b), .m0_int_o(m0_int_b),
    .m1_cyc_i(m1_cyc), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_datw_i(m1_datw),
    .m1_datr_o(m1_datr_b), .m1_ack_o(m1_ack_b), .m1_int_o(m1_int_b),
    .s_cyc_o(s_cyc_b), .s_we_o(s_we_b), .s_addr_o(s_addr_b), .s_datw_o(s_datw_b),
    .s_datr_i(s_datr), .s_int_i(s_int), .grant_o(grant_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [33:0] outs;
    #3;
    outs = {s_cyc, s_we, s_addr, s_datw, grant, m0_ack, m1_ack, m0_datr, m1_datr, m0_int, m1_int};
    tests++;
    if (outs !== 34'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if (grant !== 2'b00 || s_cyc !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: grant=%b s_cyc=%b want 00/0", grant, s_cyc);
    end
  endtask

  task automatic test_tie_alternate();
    logic [1:0] g0 [8];
    logic [1:0] g1 [6];
    int n0 = 0;
    int n1 = 0;
    m0_cyc = 1'b1; m0_we = 1'b0; m0_addr = 2'd0;
    m1_cyc = 1'b1; m1_we = 1'b0; m1_addr = 2'd1;
    s_datr = 8'h11;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (s_cyc && n0 < 8) begin g0[n0] = grant; n0++; end
      if (s_cyc_b && n1 < 6) begin g1[n1] = grant_b; n1++; end
    end
    tests++;
    if (n0 != 8 || n1 != 6) begin
      fails++;
      $display("FAIL tie_strobe_count: got %0d/%0d want 8/6", n0, n1);
    end
    for (int i = 0; i < n0; i++) begin
      tests++;
      if (g0[i] !== ((i < 4) ? 2'b01 : 2'b10)) begin
        fails++;
        $display("FAIL burst4_grant[%0d]: got %b want %b", i, g0[i], (i < 4) ? 2'b01 : 2'b10);
      end
    end
    for (int i = 0; i < n1; i++) begin
      tests++;
      if (g1[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        fails++;
        $display("FAIL alternate_grant[%0d]: got %b want %b", i, g1[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    repeat (8) tick();
    tests++;
    if (grant !== 2'b00 || grant_b !== 2'b00) begin
      fails++;
      $display("FAIL tie_drain_idle: got %b/%b want 00/00", grant, grant_b);
    end
  endtask

  task automatic test_read();
    tick();
    m0_cyc = 1'b1; m0_we = 1'b0; m0_addr = 2'd2; s_datr = 8'hA5;
    tick();
    tests++;
    if ({s_cyc, s_we, s_addr, grant} !== {1'b1, 1'b0, 2'd2, 2'b01}) begin
      fails++;
      $display("FAIL read_strobe: got cyc=%b we=%b addr=%0d grant=%b want 1/0/2/01", s_cyc, s_we, s_addr, grant);
    end
    tick();
    tests++;
    if (s_cyc !== 1'b0 || m0_ack !== 1'b0) begin
      fails++;
      $display("FAIL read_wait: got cyc=%b ack=%b want 0/0", s_cyc, m0_ack);
    end
    tick();
    tests++;
    if ({m0_ack, m1_ack, m0_datr} !== {1'b1, 1'b0, 8'hA5}) begin
      fails++;
      $display("FAIL read_ack: got ack0=%b ack1=%b datr=%h want 1/0/a5", m0_ack, m1_ack, m0_datr);
    end
    m0_cyc = 1'b0; s_datr = 8'h00;
    tick();
    tests++;
    if (m0_ack !== 1'b0) begin
      fails++;
      $display("FAIL read_ack_one_cycle: got %b want 0", m0_ack);
    end
    tick();
    tests++;
    if (grant !== 2'b00 || m0_datr !== 8'hA5) begin
      fails++;
      $display("FAIL read_idle: got grant=%b datr=%h want 00/a5", grant, m0_datr);
    end
  endtask

  task automatic test_burst();
    logic [1:0] gl [8];
    logic [7:0] dl [8];
    int tl [8];
    logic [1:0] eg [7];
    logic [7:0] ed [7];
    int ns = 0;
    int acks0 = 0;
    eg[0] = 2'b01; eg[1] = 2'b01; eg[2] = 2'b01; eg[3] = 2'b01;
    eg[4] = 2'b10; eg[5] = 2'b01; eg[6] = 2'b01;
    ed[0] = 8'h01; ed[1] = 8'h02; ed[2] = 8'h03; ed[3] = 8'h04;
    ed[4] = 8'h77; ed[5] = 8'h05; ed[6] = 8'h06;
    tick();
    m0_cyc = 1'b1; m0_we = 1'b1; m0_addr = 2'd0; m0_datw = 8'h01;
    m1_we = 1'b1; m1_addr = 2'd3; m1_datw = 8'h77;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) m1_cyc = 1'b1;
      if (s_cyc && ns < 8) begin
        gl[ns] = grant; dl[ns] = s_datw; tl[ns] = c; ns++;
      end
      if (m0_ack) begin
        acks0++;
        if (acks0 == 6) m0_cyc = 1'b0;
        else m0_datw = 8'(acks0 + 1);
      end
      if (m1_ack) m1_cyc = 1'b0;
    end
    tests++;
    if (ns != 7 || acks0 != 6) begin
      fails++;
      $display("FAIL burst_counts: got strobes=%0d acks=%0d want 7/6", ns, acks0);
    end
    for (int i = 0; i < 7; i++) begin
      if (i < ns) begin
        tests++;
        if (gl[i] !== eg[i] || dl[i] !== ed[i]) begin
          fails++;
          $display("FAIL burst_access[%0d]: got grant=%b datw=%h want %b/%h", i, gl[i], dl[i], eg[i], ed[i]);
        end
      end
    end
    if (ns >= 2) begin
      tests++;
      if (tl[1] - tl[0] != 4) begin
        fails++;
        $display("FAIL burst_spacing: got %0d want 4", tl[1] - tl[0]);
      end
    end
    m0_we = 1'b0; m1_we = 1'b0;
  endtask

  task automatic test_drop();
    logic got = 1'b0;
    int extra = 0;
    logic sawack = 1'b0;
    tick();
    m1_cyc = 1'b1; m1_we = 1'b0; m1_addr = 2'd1; s_datr = 8'h3C;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (m1_ack) got = 1'b1;
    end
    tests++;
    if (got !== 1'b1 || m1_datr !== 8'h3C || m0_ack !== 1'b0) begin
      fails++;
      $display("FAIL m1_read: got ack=%b datr=%h ack0=%b want 1/3c/0", got, m1_datr, m0_ack);
    end
    m1_cyc = 1'b0;
    repeat (2) tick();
    m1_cyc = 1'b1; s_datr = 8'hFF;
    tick();
    tests++;
    if (s_cyc !== 1'b1 || grant !== 2'b10) begin
      fails++;
      $display("FAIL drop_strobe: got cyc=%b grant=%b want 1/10", s_cyc, grant);
    end
    tick();
    m1_cyc = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (s_cyc) extra++;
      if (m1_ack) sawack = 1'b1;
    end
    tests++;
    if (extra != 0 || sawack !== 1'b0 || m1_datr !== 8'h3C || grant !== 2'b00) begin
      fails++;
      $display("FAIL drop_discard: got strobes=%0d ack=%b datr=%h grant=%b want 0/0/3c/00",
               extra, sawack, m1_datr, grant);
    end
  endtask

  task automatic test_reset_mid();
    logic [33:0] outs;
    logic [1:0] g2 = 2'b00;
    logic seen = 1'b0;
    tick();
    m0_cyc = 1'b1; m0_we = 1'b1; m0_addr = 2'd1; m0_datw = 8'h55;
    tick();
    tests++;
    if (s_cyc !== 1'b1 || s_we !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_strobe: got cyc=%b we=%b want 1/1", s_cyc, s_we);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (s_cyc !== 1'b0 || s_we !== 1'b0 || grant !== 2'b00) begin
      fails++;
      $display("FAIL rstmid_async: got cyc=%b we=%b grant=%b want 0/0/00", s_cyc, s_we, grant);
    end
    m0_we = 1'b0; m0_addr = 2'd0; m1_we = 1'b0;
    m1_cyc = 1'b1;
    #2;
    rst_n = 1'b1;
    #1;
    outs = {s_cyc, s_we, s_addr, s_datw, grant, m0_ack, m1_ack, m0_datr, m1_datr, m0_int, m1_int};
    tests++;
    if (outs !== 34'd0) begin
      fails++;
      $display("FAIL rstmid_outputs: got %h want 0", outs);
    end
    tick();
    tests++;
    if (s_cyc !== 1'b1 || grant !== 2'b01) begin
      fails++;
      $display("FAIL rstmid_first_tie: got cyc=%b grant=%b want 1/01", s_cyc, grant);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m0_ack) m0_cyc = 1'b0;
      if (m1_ack) m1_cyc = 1'b0;
      if (s_cyc && !seen) begin g2 = grant; seen = 1'b1; end
    end
    tests++;
    if (seen !== 1'b1 || g2 !== 2'b10) begin
      fails++;
      $display("FAIL rstmid_second: got seen=%b grant=%b want 1/10", seen, g2);
    end
  endtask

  task automatic test_int();
    tick();
    s_int = 1'b1;
    tests++;
    if (m0_int !== 1'b0 || m1_int !== 1'b0) begin
      fails++;
      $display("FAIL int_early: got %b%b want 00", m0_int, m1_int);
    end
    tick();
    tests++;
    if (m0_int !== 1'b1 || m1_int !== 1'b1) begin
      fails++;
      $display("FAIL int_rise: got %b%b want 11", m0_int, m1_int);
    end
    s_int = 1'b0;
    tick();
    tests++;
    if (m0_int !== 1'b0 || m1_int !== 1'b0) begin
      fails++;
      $display("FAIL int_fall: got %b%b want 00", m0_int, m1_int);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tie_alternate();
    test_read();
    test_burst();
    test_drop();
    test_reset_mid();
    test_int();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
